sha_logic_unit: RTL and testbench
=================================

// Module: sha_logic_unit
// PURPOSE
//  Parametrised, pipelined bitwise-logic unit for the SHA datapath. It supersedes the
//  fixed-width combinational XOR cell.
//  Evaluates 2/3-operand XOR, AND, OR, NOT and the SHA-256 Ch, Maj and rotate-XOR (Sigma)
//  functions. Two register stages with valid/ready flow control on both sides.
//  Sits between operand fetch and the SHA round adder tree.
// PARAMETERS
//  WIDTH    32               operand/result width in bits (>=8)
//  RW       $clog2(WIDTH)    rotate-amount field width (derived, do not override)
//  CNT_W    16               width of the completed-operation counter
// PORTS
//  clk        in   1        single clock, rising edge
//  rst        in   1        synchronous reset, active-high
//  in_valid   in   1        operand/op bundle valid
//  in_ready   out  1        unit can accept a bundle this cycle
//  op         in   3        operation code (sha_alu_pkg::logic_op_e)
//  a,b,c      in   WIDTH    operands
//  rot        in   3*RW     rotate amounts {r2,r1,r0}; used by OP_SIGMA only
//  out_valid  out  1        result valid
//  out_ready  in   1        downstream accepts result
//  res        out  WIDTH    result
//  res_zero   out  1        res == 0
//  op_count   out  CNT_W    number of results accepted downstream; saturates
// BEHAVIOUR
//  - Reset: on rst=1 at a clk edge, both stage valids, out_valid, res, res_zero and
//    op_count all clear to 0. In-flight data is discarded.
//  - Stage data regs are don't-care after reset; outputs are forced 0 while out_valid=0.
//  - Ops:
//      0 XOR2  a^b
//      1 XOR3  a^b^c
//      2 AND   a&b
//      3 OR    a|b
//      4 NOT   ~a
//      5 CH    (a&b)^(~a&c)
//      6 MAJ   (a&b)^(a&c)^(b&c)
//      7 SIGMA rotr(a,r0)^rotr(a,r1)^rotr(a,r2)
//  - Rotate amounts are taken modulo WIDTH; amount 0 passes a unchanged.
//    Unused operands are ignored.
//  - Width rules: all results are exactly WIDTH bits. No sign or carry semantics.
//  - Stage 1 (S1): function result is registered together with s1_valid.
//  - Stage 2 (S2): registers res, res_zero and s2_valid. out_valid = s2_valid.
//  - Latency: 2 cycles from the in_valid&&in_ready edge to out_valid when unstalled.
//    Throughput is 1 result per cycle.
//  - Flow control:
//      s2_en    = !s2_valid || out_ready
//      s1_en    = !s1_valid || s2_en
//      in_ready = s1_en      (combinational chain, no bubble under full flow)
//  - Transfers:
//      in_valid && in_ready  loads S1
//      s1_valid && s2_en     loads S2
//      no new S1 load        s1_valid drops when S1 moves on
//  - Stall: while out_valid && !out_ready, res/res_zero hold bit-stable.
//    S1 holds if also valid; in_ready=0 once both stages are full.
//  - Simultaneous accept-out and accept-in on a full pipe: both happen in the same
//    cycle, and no data is lost or duplicated.
//  - op_count increments on each out_valid && out_ready.
//    It holds at 2**CNT_W-1 (no wrap).
//  - Reset mid-stall takes precedence over every transfer in that cycle.
//  - in_valid may deassert without a handshake. No data is captured unless in_ready=1.
// STRUCTURE
//  - Package sha_alu_pkg holds:
//      typedef enum logic [2:0] logic_op_e {OP_XOR2, OP_XOR3, OP_AND, OP_OR,
//                                           OP_NOT, OP_CH, OP_MAJ, OP_SIGMA}
//      localparam SHA_WORD = 32
//  - Sub-module rotr_xor3 #(WIDTH): purely combinational three-way rotate-right XOR
//    used for OP_SIGMA.
//  - Pipeline control, counter and op mux live in the top module.
// TESTING
//  1. Reset: assert rst 2 cycles mid-traffic -> out_valid=0, in_ready=1, op_count=0,
//     res=0 on the next cycle.
//  2. Ops, WIDTH=32, out_ready=1, with a=32'hF0F0_1234, b=32'h0FF0_5678, c=32'hAAAA_5555:
//      XOR2 -> 32'hFF00_444C
//      AND  -> 32'h00F0_1230
//      CH   -> 32'h00F0_1230 ^ (32'h0F0F_EDCB & c) = 32'h0AFA_5771
//     Each result appears exactly 2 cycles after acceptance.
//  3. SIGMA0: a=32'h6A09_E667, rot={22,13,2} -> res=32'hCE20_B47E,
//     res_zero=0. Also rot={0,0,0} -> res=a.
//  4. Backpressure: stream 8 XOR3 ops with out_ready toggled at random.
//     Results must arrive in order with no loss or duplication, res stable while
//     stalled, and in_ready=0 when both stages are full.
//  5. Zero/saturation: a=b gives XOR2 -> res=0 and res_zero=1.
//     With CNT_W=4, complete 20 ops -> op_count stops at 15.
//  6. Full-pipe simultaneous in/out handshake for 10 back-to-back cycles
//     -> exactly 1 result per cycle.

Source files
------------

// File: rtl/sha_alu_pkg.sv
// Shared types for the SHA datapath logic unit: operation codes and the native word size.
package sha_alu_pkg;

    localparam int SHA_WORD = 32;

    typedef enum logic [2:0] {
        OP_XOR2  = 3'd0,
        OP_XOR3  = 3'd1,
        OP_AND   = 3'd2,
        OP_OR    = 3'd3,
        OP_NOT   = 3'd4,
        OP_CH    = 3'd5,
        OP_MAJ   = 3'd6,
        OP_SIGMA = 3'd7
    } logic_op_e;

endpackage

// File: rtl/rotr_xor3.sv
// Combinational three-way rotate-right XOR, the core of the SHA-256 Sigma functions.
module rotr_xor3
    import sha_alu_pkg::*;
#(
    parameter  int WIDTH = SHA_WORD,
    localparam int RW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]  x_i,
    input  logic [3*RW-1:0]   rot_i,
    output logic [WIDTH-1:0]  y_o
);

    // Amounts wrap modulo WIDTH so non-power-of-two widths still rotate correctly.
    function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x, input logic [RW-1:0] amt);
        logic [2*WIDTH-1:0] dbl;
        int unsigned        sh;
        sh  = 32'(amt) % WIDTH;
        dbl = {x, x} >> sh;
        return dbl[WIDTH-1:0];
    endfunction

    assign y_o = rotr(x_i, rot_i[RW-1:0])
               ^ rotr(x_i, rot_i[2*RW-1:RW])
               ^ rotr(x_i, rot_i[3*RW-1:2*RW]);

endmodule

// File: rtl/sha_logic_unit.sv
// Two-stage pipelined bitwise-logic unit (XOR/AND/OR/NOT/Ch/Maj/Sigma) with valid/ready
// handshakes on both sides and a saturating count of delivered results.
module sha_logic_unit
    import sha_alu_pkg::*;
#(
    parameter  int WIDTH = SHA_WORD,
    parameter  int CNT_W = 16,
    localparam int RW    = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic_op_e         op,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [WIDTH-1:0]  c,
    input  logic [3*RW-1:0]   rot,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  res,
    output logic              res_zero,
    output logic [CNT_W-1:0]  op_count
);

    logic [WIDTH-1:0] sigma;
    logic [WIDTH-1:0] func;

    logic             s2_en;
    logic             s1_en;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_data_q,  s1_data_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] res_q,      res_d;
    logic             zero_q,     zero_d;
    logic [CNT_W-1:0] count_q,    count_d;

    rotr_xor3 #(.WIDTH(WIDTH)) u_sigma (
        .x_i   (a),
        .rot_i (rot),
        .y_o   (sigma)
    );

    always_comb begin
        func = '0;
        case (op)
            OP_XOR2:  func = a ^ b;
            OP_XOR3:  func = a ^ b ^ c;
            OP_AND:   func = a & b;
            OP_OR:    func = a | b;
            OP_NOT:   func = ~a;
            OP_CH:    func = (a & b) ^ (~a & c);
            OP_MAJ:   func = (a & b) ^ (a & c) ^ (b & c);
            OP_SIGMA: func = sigma;
            default:  func = '0;
        endcase
    end

    // Ready ripples back from the output so a full pipe still moves one word per cycle.
    always_comb begin
        s2_en      = !s2_valid_q || out_ready;
        s1_en      = !s1_valid_q || s2_en;
        in_ready   = s1_en;

        s1_valid_d = s1_en ? in_valid : s1_valid_q;
        s1_data_d  = (s1_en && in_valid) ? func : s1_data_q;

        s2_valid_d = s2_en ? s1_valid_q : s2_valid_q;
        res_d      = res_q;
        zero_d     = zero_q;
        if (s2_en && s1_valid_q) begin
            res_d  = s1_data_q;
            zero_d = (s1_data_q == '0);
        end

        count_d = count_q;
        if (s2_valid_q && out_ready && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            res_q      <= '0;
            zero_q     <= 1'b0;
            count_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            res_q      <= res_d;
            zero_q     <= zero_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        s1_data_q <= s1_data_d;
    end

    assign out_valid = s2_valid_q;
    assign res       = s2_valid_q ? res_q : '0;
    assign res_zero  = s2_valid_q & zero_q;
    assign op_count  = count_q;

endmodule

// File: tb/tb_sha_logic_unit.sv
// Directed bench for sha_logic_unit: an op vector table, reset mid-traffic, backpressure,
// full-pipe streaming and op_count saturation (counter narrowed to 4 bits).
module tb_sha_logic_unit;
    import sha_alu_pkg::*;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;
    localparam int RW    = $clog2(WIDTH);
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic_op_e         op;
    logic [WIDTH-1:0]  a, b, c;
    logic [3*RW-1:0]   rot;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  res;
    logic              res_zero;
    logic [CNT_W-1:0]  op_count;

    typedef struct {
        logic_op_e        op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] c;
        logic [3*RW-1:0]  rot;
        logic [WIDTH-1:0] expRes;
        logic             expZero;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs [NVEC];

    int total    = 0;
    int bad      = 0;
    int expCount = 0;

    sha_logic_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .c         (c),
        .rot       (rot),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .res_zero  (res_zero),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic bumpCount();
        if (expCount < CMAX) expCount++;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // One op through an empty pipe: accept, check latency, check result, let it drain.
    task automatic applyStimulus(input vec_t v, input int idx);
        op        = v.op;
        a         = v.a;
        b         = v.b;
        c         = v.c;
        rot       = v.rot;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        checkOutput($sformatf("v%0d in_ready", idx), 32'(in_ready), 32'd1);
        nextCycle();
        in_valid = 1'b0;
        checkOutput($sformatf("v%0d early valid", idx), 32'(out_valid), 32'd0);
        nextCycle();
        checkOutput($sformatf("v%0d out_valid", idx), 32'(out_valid), 32'd1);
        checkOutput($sformatf("v%0d res", idx), res, v.expRes);
        checkOutput($sformatf("v%0d res_zero", idx), 32'(res_zero), 32'(v.expZero));
        bumpCount();
        nextCycle();
        checkOutput($sformatf("v%0d drained", idx), 32'(out_valid), 32'd0);
        checkOutput($sformatf("v%0d op_count", idx), 32'(op_count), 32'(expCount));
    endtask

    // mode 0: stall 3 cycles then random out_ready; mode 1: stall 3 then always ready;
    // mode 2: always ready.
    task automatic streamOps(input int n, input int mode, output int bothFire);
        logic [WIDTH-1:0] q[$];
        logic [WIDTH-1:0] prevRes;
        logic [WIDTH-1:0] expv;
        logic             stalledPrev;
        logic             inFire, outFire;
        int sent, got, cyc, inflight;
        sent = 0; got = 0; cyc = 0; bothFire = 0;
        stalledPrev = 1'b0;
        prevRes = '0;
        while (got < n && cyc < 300) begin
            case (mode)
                0:       out_ready = (cyc < 3) ? 1'b0 : 1'($urandom_range(0, 1));
                1:       out_ready = (cyc >= 3);
                default: out_ready = 1'b1;
            endcase
            in_valid = (sent < n);
            op       = OP_XOR3;
            a        = 32'hA5A5_0000 | 32'(sent);
            b        = 32'h0F0F_F0F0 ^ (32'(sent) << 8);
            c        = 32'h3C3C_3C3C + 32'(sent);
            rot      = '0;
            #1;
            inflight = sent - got;
            checkOutput("stream op_count", 32'(op_count), 32'(expCount));
            checkOutput("stream in_ready", 32'(in_ready),
                        32'(!(inflight == 2 && !out_ready)));
            if (stalledPrev) begin
                checkOutput("stall valid", 32'(out_valid), 32'd1);
                checkOutput("stall res", res, prevRes);
            end
            outFire = out_valid && out_ready;
            inFire  = in_valid && in_ready;
            if (outFire) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL spurious result: got %h, expected none", res);
                end else begin
                    expv = q.pop_front();
                    checkOutput($sformatf("stream res %0d", got), res, expv);
                end
                got++;
                bumpCount();
            end
            if (inFire) begin
                q.push_back(a ^ b ^ c);
                sent++;
            end
            if (inFire && outFire) bothFire++;
            stalledPrev = out_valid && !out_ready;
            prevRes     = res;
            nextCycle();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (got < n) begin
            total++;
            bad++;
            $display("[TB] FAIL stream timeout: got %0d results, expected %0d", got, n);
        end
        checkOutput("stream final count", 32'(op_count), 32'(expCount));
    endtask

    initial begin
        int fires;
        logic [WIDTH-1:0] ka, kb, kc;
        ka = 32'hF0F0_1234;
        kb = 32'h0FF0_5678;
        kc = 32'hAAAA_5555;
        vecs[0]  = '{OP_XOR2,  ka, kb, kc, '0, 32'hFF00_444C, 1'b0};
        vecs[1]  = '{OP_XOR3,  ka, kb, kc, '0, 32'h55AA_1119, 1'b0};
        vecs[2]  = '{OP_AND,   ka, kb, kc, '0, 32'h00F0_1230, 1'b0};
        vecs[3]  = '{OP_OR,    ka, kb, kc, '0, 32'hFFF0_567C, 1'b0};
        vecs[4]  = '{OP_NOT,   ka, kb, kc, '0, 32'h0F0F_EDCB, 1'b0};
        vecs[5]  = '{OP_CH,    ka, kb, kc, '0, 32'h0AFA_5771, 1'b0};
        vecs[6]  = '{OP_MAJ,   ka, kb, kc, '0, 32'hAAF0_5674, 1'b0};
        vecs[7]  = '{OP_SIGMA, 32'h6A09_E667, kb, kc, {5'd22, 5'd13, 5'd2}, 32'hCE20_B47E, 1'b0};
        vecs[8]  = '{OP_SIGMA, 32'h6A09_E667, kb, kc, {5'd0, 5'd0, 5'd0}, 32'h6A09_E667, 1'b0};
        vecs[9]  = '{OP_SIGMA, 32'h0000_0001, kb, kc, {5'd0, 5'd1, 5'd2}, 32'hC000_0001, 1'b0};
        vecs[10] = '{OP_XOR2,  32'h1234_5678, 32'h1234_5678, kc, '0, 32'h0000_0000, 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = OP_XOR2; a = '0; b = '0; c = '0; rot = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset op_count", 32'(op_count), 32'd0);
        checkOutput("reset res", res, 32'd0);

        for (int i = 0; i < NVEC; i++) applyStimulus(vecs[i], i);

        // Fill the pipe while stalled, then reset with both handshakes requested.
        in_valid = 1'b1; out_ready = 1'b0; op = OP_OR; a = ka; b = kb; c = kc;
        nextCycle();
        nextCycle();
        checkOutput("prefill stalled", 32'(out_valid), 32'd1);
        rst = 1'b1; out_ready = 1'b1;
        nextCycle();
        checkOutput("mid-reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("mid-reset op_count", 32'(op_count), 32'd0);
        nextCycle();
        rst = 1'b0; in_valid = 1'b0;
        expCount = 0;
        checkOutput("post-reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("post-reset in_ready", 32'(in_ready), 32'd1);
        checkOutput("post-reset op_count", 32'(op_count), 32'd0);
        checkOutput("post-reset res", res, 32'd0);
        checkOutput("post-reset res_zero", 32'(res_zero), 32'd0);
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            checkOutput("flushed data", 32'(out_valid), 32'd0);
        end

        streamOps(8, 0, fires);

        streamOps(12, 1, fires);
        checkOutput("full-pipe both-fire cycles", 32'(fires), 32'd10);

        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        expCount = 0;
        streamOps(20, 2, fires);
        checkOutput("saturated op_count", 32'(op_count), 32'(CMAX));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected done", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
